// File: rtl/fir_stream_ctrl.sv
// Packs a scalar sample stream into R-lane FIR beats, serialises results back out, and appends zero beats for the convolution tail.
// Latency: lane R-1 accepted -> fir_ce next cycle -> first m_valid two cycles later; input stalls while a packed word waits on an undrained buffer.
module fir_stream_ctrl #(
   parameter int super_ratio = 4,
   parameter int nTap        = 9
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [31:0]               s_data,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic                      s_last,
   output logic [31:0]               m_data,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic                      m_last,
   output logic [32*super_ratio-1:0] fir_din,
   output logic                      fir_ce,
   input  logic [32*super_ratio-1:0] fir_dout,
   output logic                      busy
);

   localparam int R  = super_ratio;
   localparam int LW = $clog2(R + 1);

   typedef enum logic [1:0] {IDLE, CAP, TAIL} state_t;

   state_t              state, state_nxt;
   logic [32*R-1:0]     pword;
   logic [LW-1:0]       pcnt;
   logic                pfull;
   logic                last_seen;
   logic [31:0]         ocount;
   logic [31:0]         issued;
   logic [32*R-1:0]     obuf;
   logic                bvld;
   logic [LW-1:0]       vcnt;
   logic [LW-1:0]       ocnt;
   logic                final_beat;

   logic                s_acc, m_acc, blk_done, more_tail;
   logic [31:0]         owed_left;
   logic [LW-1:0]       beat_lanes;

   assign s_acc     = s_valid && s_ready;
   assign m_acc     = m_valid && m_ready;
   assign blk_done  = m_acc && m_last;
   assign owed_left = ocount - issued;
   assign more_tail = last_seen && (owed_left > 32'(R));

   always_comb begin
      beat_lanes = LW'(R);
      if (last_seen && (owed_left < 32'(R)))
         beat_lanes = owed_left[LW-1:0];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pfull && !bvld) state_nxt = CAP;
         CAP:     state_nxt = more_tail ? TAIL : IDLE;
         TAIL:    if (!bvld) state_nxt = CAP;
         default: state_nxt = IDLE;
      endcase
      if (blk_done)
         state_nxt = IDLE;
   end

   // Once s_last is in, the packer stays closed until the block's final output
   // handshake so the next block's samples never mix with this block's counters.
   always_comb begin
      fir_ce  = ((state == IDLE) && pfull && !bvld) || ((state == TAIL) && !bvld);
      fir_din = '0;
      if (fir_ce && (state == IDLE))
         fir_din = pword;
      s_ready = !pfull && (state != TAIL) && !last_seen;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pword      <= '0;
         pcnt       <= '0;
         pfull      <= 1'b0;
         last_seen  <= 1'b0;
         ocount     <= '0;
         issued     <= '0;
         obuf       <= '0;
         bvld       <= 1'b0;
         vcnt       <= '0;
         ocnt       <= '0;
         final_beat <= 1'b0;
         busy       <= 1'b0;
      end else if (blk_done) begin
         pword      <= '0;
         pcnt       <= '0;
         pfull      <= 1'b0;
         last_seen  <= 1'b0;
         ocount     <= '0;
         issued     <= '0;
         bvld       <= 1'b0;
         ocnt       <= '0;
         final_beat <= 1'b0;
         busy       <= 1'b0;
      end else begin
         // Lanes are zeroed after every beat, so a short last word is already zero-padded.
         if (fir_ce) begin
            pword <= '0;
            pcnt  <= '0;
            pfull <= 1'b0;
         end else if (s_acc) begin
            for (int i = 0; i < R; i++)
               if (pcnt == LW'(i))
                  pword[32*i +: 32] <= s_data;
            pcnt <= pcnt + LW'(1);
            if ((pcnt == LW'(R - 1)) || s_last)
               pfull <= 1'b1;
         end

         if (s_acc) begin
            busy      <= 1'b1;
            ocount    <= s_last ? ocount + 32'(nTap) : ocount + 32'd1;
            last_seen <= last_seen || s_last;
         end

         if (state == CAP) begin
            obuf       <= fir_dout;
            bvld       <= 1'b1;
            vcnt       <= beat_lanes;
            ocnt       <= '0;
            final_beat <= last_seen && !more_tail;
            issued     <= issued + 32'(beat_lanes);
         end else if (m_acc) begin
            if (ocnt == vcnt - LW'(1)) begin
               bvld <= 1'b0;
               ocnt <= '0;
            end else begin
               ocnt <= ocnt + LW'(1);
            end
         end
      end
   end

   always_comb begin
      m_data = '0;
      for (int i = 0; i < R; i++)
         if (ocnt == LW'(i))
            m_data = obuf[32*i +: 32];
   end

   assign m_valid = bvld;
   assign m_last  = bvld && final_beat && (ocnt == vcnt - LW'(1));

endmodule
